// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the prefetching instruction-fetch stage.
package fetch_queue_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Decode-side handshake and RAM port B bundle of the fetch stage.
interface fetch_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 4
);
   import fetch_queue_pkg::*;

   localparam int COUNT_WIDTH = clog2(DEPTH) + 1;

   logic                   jump;
   logic [31:0]            target;
   logic                   stall;
   logic                   ram_en_b;
   logic [ADDR_WIDTH-1:0]  ram_addr_b;
   logic [DATA_WIDTH-1:0]  ram_rdata_b;
   logic                   valid_id;
   logic [31:0]            pc_id;
   logic [DATA_WIDTH-1:0]  ir_id;
   logic [COUNT_WIDTH-1:0] count;

   // Fetch stage side.
   modport master (
      input  jump, target, stall, ram_rdata_b,
      output ram_en_b, ram_addr_b, valid_id, pc_id, ir_id, count
   );

   // Decode stage and instruction RAM side.
   modport slave (
      output jump, target, stall, ram_rdata_b,
      input  ram_en_b, ram_addr_b, valid_id, pc_id, ir_id, count
   );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; head is read combinationally.
module fetch_fifo #(
   parameter int WIDTH       = 64,
   parameter int DEPTH       = 4,
   parameter int COUNT_WIDTH = fetch_queue_pkg::clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   empty,
   output logic                   full
);
   import fetch_queue_pkg::*;

   localparam int PTR_WIDTH = clog2(DEPTH);

   logic [WIDTH-1:0]       mem_reg [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_reg;
   logic [PTR_WIDTH-1:0]   rd_ptr_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic                   do_push;
   logic                   do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == COUNT_WIDTH'(DEPTH));
   assign do_push = push & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: credit-based sequential reads on RAM port B feed a
// small queue presented to decode; a jump flushes the queue and redirects.
module fetch_queue #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 9,
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_PC   = fetch_queue_pkg::DEFAULT_RESET_PC
) (
   input logic         clk,
   input logic         rst,
   fetch_queue_if.master bus
);
   import fetch_queue_pkg::*;

   localparam int COUNT_WIDTH = clog2(DEPTH) + 1;
   localparam int ENTRY_WIDTH = 32 + DATA_WIDTH;

   logic [31:0]            fetch_pc_reg, fetch_pc_next;
   logic                   inflight_reg, inflight_next;
   logic                   kill_reg, kill_next;
   logic [ENTRY_WIDTH-1:0] head;
   logic [COUNT_WIDTH-1:0] occupancy;
   logic [COUNT_WIDTH:0]   credit;
   logic                   empty, full;
   logic                   pop, push, issue;

   assign pop    = bus.valid_id & ~bus.stall & ~bus.jump;
   assign push   = inflight_reg & ~kill_reg & ~full;
   // Entries already queued plus the one in flight, less the one leaving now.
   assign credit = {1'b0, occupancy} + (COUNT_WIDTH+1)'(inflight_reg)
                   - (COUNT_WIDTH+1)'(pop);
   assign issue  = ~rst & ~bus.jump & (credit < (COUNT_WIDTH+1)'(DEPTH));

   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      inflight_next = issue;
      kill_next     = 1'b0;
      if (bus.jump) begin
         fetch_pc_next = bus.target & 32'hFFFF_FFFC;
         kill_next     = inflight_reg;
      end else if (issue) begin
         fetch_pc_next = fetch_pc_reg + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         inflight_reg <= 1'b0;
         kill_reg     <= 1'b0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         inflight_reg <= inflight_next;
         kill_reg     <= kill_next;
      end
   end

   // A returning read was issued last cycle with no jump since, so its PC
   // is exactly one word behind fetch_pc_reg.
   fetch_fifo #(
      .WIDTH       (ENTRY_WIDTH),
      .DEPTH       (DEPTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.jump),
      .din   ({fetch_pc_reg - 32'd4, bus.ram_rdata_b}),
      .dout  (head),
      .count (occupancy),
      .empty (empty),
      .full  (full)
   );

   assign bus.ram_en_b   = issue;
   assign bus.ram_addr_b = fetch_pc_reg[ADDR_WIDTH+1:2];
   assign bus.valid_id   = ~empty;
   assign bus.pc_id      = empty ? 32'd0 : head[ENTRY_WIDTH-1:DATA_WIDTH];
   assign bus.ir_id      = empty ? DATA_WIDTH'(NOP_INSTR) : head[DATA_WIDTH-1:0];
   assign bus.count      = occupancy;

endmodule
